sysid_checker: RTL and testbench

Avalon-MM read master that interrogates the system-ID slave over its control interface. It fetches the ID word (word address 0) and the build-timestamp word (word address 1), then compares both against compile-time expected values. Pass/fail, mismatch and timeout flags are reported so that board bring-up logic or an LED can reject a mismatched FPGA image before the processor boots. It sits in the SoC top level and connects through the interconnect to the sysid slave's control port.

---
 rtl/sysid_checker.sv | 113 +++++++++++
 tb/tb_sysid_checker.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/sysid_checker.sv
// sysid_checker: Avalon-MM read master that fetches sysid words 0/1 and checks them against expected values
module sysid_checker #(
  parameter logic [31:0] EXPECTED_ID        = 32'd0,
  parameter logic [31:0] EXPECTED_TIMESTAMP = 32'd1489295197,
  parameter int unsigned TIMEOUT_CYCLES     = 255,
  parameter bit          AUTO_START         = 1'b1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  output logic        address,
  output logic        read,
  input  logic        waitrequest,
  input  logic [31:0] readdata,
  input  logic        readdatavalid,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic        id_mismatch,
  output logic        ts_mismatch,
  output logic        timeout,
  output logic [31:0] id_value,
  output logic [31:0] ts_value
);
  typedef enum logic [2:0] {IDLE, ID_CMD, ID_WAIT, TS_CMD, TS_WAIT, DONE} state_t;
  localparam logic [15:0] TO = 16'(TIMEOUT_CYCLES);
  state_t state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic first_q, done_q, done_d, pass_q, pass_d, id_mm_q, id_mm_d, ts_mm_q, ts_mm_d, to_q, to_d;
  logic [31:0] id_val_q, id_val_d, ts_val_q, ts_val_d;
  logic cmd, wt, acc, ts_acc, cap, go;
  always_comb begin
    cmd = state_q == ID_CMD || state_q == TS_CMD;
    wt = state_q == ID_WAIT || state_q == TS_WAIT;
    acc = cmd || wt;
    ts_acc = state_q == TS_CMD || state_q == TS_WAIT;
    cap = readdatavalid && (wt || (cmd && !waitrequest));
    go = (state_q == IDLE && (start || (AUTO_START && first_q))) || (state_q == DONE && start);
    state_d = state_q;
    cnt_d = acc ? cnt_q + 16'd1 : cnt_q;
    done_d = done_q;
    pass_d = pass_q;
    id_mm_d = id_mm_q;
    ts_mm_d = ts_mm_q;
    to_d = to_q;
    id_val_d = id_val_q;
    ts_val_d = ts_val_q;
    if (go) begin
      state_d = ID_CMD;
      cnt_d = '0;
      done_d = 1'b0;
      pass_d = 1'b0;
      id_mm_d = 1'b0;
      ts_mm_d = 1'b0;
      to_d = 1'b0;
      id_val_d = '0;
      ts_val_d = '0;
    end else if (acc && cap && ts_acc) begin
      state_d = DONE;
      ts_val_d = readdata;
      ts_mm_d = readdata != EXPECTED_TIMESTAMP;
      done_d = 1'b1;
      pass_d = !id_mm_q && readdata == EXPECTED_TIMESTAMP;
    end else if (acc && cap) begin
      state_d = TS_CMD;
      cnt_d = '0;
      id_val_d = readdata;
      id_mm_d = readdata != EXPECTED_ID;
    end else if (acc && cnt_q == TO) begin
      state_d = DONE;
      done_d = 1'b1;
      to_d = 1'b1;
      pass_d = 1'b0;
    end else if (cmd && !waitrequest) begin
      state_d = ts_acc ? TS_WAIT : ID_WAIT;
    end
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q <= '0;
      first_q <= 1'b1;
      done_q <= 1'b0;
      pass_q <= 1'b0;
      id_mm_q <= 1'b0;
      ts_mm_q <= 1'b0;
      to_q <= 1'b0;
      id_val_q <= '0;
      ts_val_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      first_q <= 1'b0;
      done_q <= done_d;
      pass_q <= pass_d;
      id_mm_q <= id_mm_d;
      ts_mm_q <= ts_mm_d;
      to_q <= to_d;
      id_val_q <= id_val_d;
      ts_val_q <= ts_val_d;
    end
  end
  assign read = state_q == ID_CMD || state_q == TS_CMD;
  assign address = state_q == TS_CMD || state_q == TS_WAIT;
  assign busy = state_q != IDLE && state_q != DONE;
  assign done = done_q;
  assign pass = pass_q;
  assign id_mismatch = id_mm_q;
  assign ts_mismatch = ts_mm_q;
  assign timeout = to_q;
  assign id_value = id_val_q;
  assign ts_value = ts_val_q;
endmodule

// File: tb/tb_sysid_checker.sv
// tb_sysid_checker: randomized self-checking bench for sysid_checker against a per-access timing model
module tb_sysid_checker;
  localparam logic [31:0] EXP_ID = 32'd0;
  localparam logic [31:0] EXP_TS = 32'd1489295197;
  logic clock = 1'b0, reset = 1'b1, start = 1'b0, waitrequest = 1'b0, readdatavalid = 1'b0, sel = 1'b0;
  logic [31:0] readdata = '0;
  logic start_a, start_b;
  logic a_addr, a_read, a_busy, a_done, a_pass, a_idm, a_tsm, a_to;
  logic b_addr, b_read, b_busy, b_done, b_pass, b_idm, b_tsm, b_to;
  logic [31:0] a_id, a_ts, b_id, b_ts;
  logic m_addr, m_read, m_busy, m_done, m_pass, m_idm, m_tsm, m_to;
  logic [31:0] m_id, m_ts;
  int n_chk = 0, n_fail = 0;
  always #5 clock = ~clock;
  assign start_a = start && !sel;
  assign start_b = start && sel;
  assign {m_addr, m_read, m_busy, m_done, m_pass, m_idm, m_tsm, m_to} = sel ?
    {b_addr, b_read, b_busy, b_done, b_pass, b_idm, b_tsm, b_to} :
    {a_addr, a_read, a_busy, a_done, a_pass, a_idm, a_tsm, a_to};
  assign m_id = sel ? b_id : a_id;
  assign m_ts = sel ? b_ts : a_ts;
  sysid_checker u_a (
    .clock(clock), .reset(reset), .start(start_a), .address(a_addr), .read(a_read),
    .waitrequest(waitrequest), .readdata(readdata), .readdatavalid(readdatavalid),
    .busy(a_busy), .done(a_done), .pass(a_pass), .id_mismatch(a_idm), .ts_mismatch(a_tsm),
    .timeout(a_to), .id_value(a_id), .ts_value(a_ts)
  );
  sysid_checker #(.TIMEOUT_CYCLES(4), .AUTO_START(1'b0)) u_b (
    .clock(clock), .reset(reset), .start(start_b), .address(b_addr), .read(b_read),
    .waitrequest(waitrequest), .readdata(readdata), .readdatavalid(readdatavalid),
    .busy(b_busy), .done(b_done), .pass(b_pass), .id_mismatch(b_idm), .ts_mismatch(b_tsm),
    .timeout(b_to), .id_value(b_id), .ts_value(b_ts)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clock);
    #1;
  endtask
  task automatic zero(input string tag);
    chk({tag, "_read"}, m_read, 0);
    chk({tag, "_addr"}, m_addr, 0);
    chk({tag, "_busy"}, m_busy, 0);
    chk({tag, "_done"}, m_done, 0);
    chk({tag, "_pass"}, m_pass, 0);
    chk({tag, "_flags"}, {m_idm, m_tsm, m_to}, 0);
    chk({tag, "_id"}, m_id, 0);
    chk({tag, "_ts"}, m_ts, 0);
  endtask
  // One check sequence: access a stalls w cycles, then returns data l cycles after
  // acceptance; it lasts min(w+l, t)+1 cycles and times out when w+l exceeds t.
  task automatic run(input bit pulse, input int t, input int w0, input int l0, input logic [31:0] d0,
                     input int w1, input int l1, input logic [31:0] d1);
    int w[2], l[2], len[2], nacc;
    logic [31:0] d[2];
    bit to[2], to_any, idm, tsm;
    w = '{w0, w1};
    l = '{l0, l1};
    d = '{d0, d1};
    for (int a = 0; a < 2; a++) begin
      to[a] = w[a] + l[a] > t;
      len[a] = (to[a] ? t : w[a] + l[a]) + 1;
    end
    nacc = to[0] ? 1 : 2;
    to_any = to[0] || to[1];
    idm = !to[0] && d[0] != EXP_ID;
    tsm = !to_any && d[1] != EXP_TS;
    if (pulse) start = 1'b1;
    for (int a = 0; a < nacc; a++) begin
      for (int k = 0; k < len[a]; k++) begin
        tick();
        start = $urandom_range(3) == 0;
        chk("busy", m_busy, 1);
        chk("read", m_read, 32'(k <= w[a]));
        if (k <= w[a]) chk("address", m_addr, a);
        if (a == 0 && k == 0) chk("cleared", {m_id | m_ts, m_done, m_pass, m_idm, m_tsm, m_to}, 0);
        waitrequest = k < w[a];
        readdatavalid = k == w[a] + l[a] || (k < w[a] && $urandom_range(1) == 1);
        readdata = k == w[a] + l[a] ? d[a] : $urandom;
      end
    end
    for (int i = 0; i < 2; i++) begin
      tick();
      start = 1'b0;
      chk("done_busy", m_busy, 0);
      chk("done", m_done, 1);
      chk("done_read", m_read, 0);
      chk("pass", m_pass, 32'(!to_any && !idm && !tsm));
      chk("id_mismatch", m_idm, 32'(idm));
      chk("ts_mismatch", m_tsm, 32'(tsm));
      chk("timeout", m_to, 32'(to_any));
      chk("id_value", m_id, to[0] ? 0 : d[0]);
      chk("ts_value", m_ts, to_any ? 0 : d[1]);
      waitrequest = $urandom_range(1) == 1;
      readdatavalid = $urandom_range(1) == 1;
      readdata = $urandom;
    end
  endtask
  initial begin
    repeat (3) tick();
    zero("rst_a");
    sel = 1'b1;
    #1;
    zero("rst_b");
    sel = 1'b0;
    #1;
    reset = 1'b0;
    run(0, 255, 0, 0, EXP_ID, 0, 0, EXP_TS);
    run(1, 255, 0, 0, EXP_ID, 0, 0, 32'h1234_5678);
    run(1, 255, 3, 1, EXP_ID, 3, 1, EXP_TS);
    run(1, 255, 0, 2, 32'h0000_DEAD, 1, 0, EXP_TS);
    sel = 1'b1;
    run(1, 4, 0, 1000, EXP_ID, 0, 0, EXP_TS);
    run(1, 4, 10, 0, EXP_ID, 0, 0, EXP_TS);
    run(1, 4, 2, 2, EXP_ID, 4, 0, EXP_TS);
    run(1, 4, 0, 0, EXP_ID, 3, 2, EXP_TS);
    for (int i = 0; i < 12; i++)
      run(1, 4, $urandom_range(4), $urandom_range(3), $urandom_range(1) ? EXP_ID : $urandom,
          $urandom_range(4), $urandom_range(3), $urandom_range(1) ? EXP_TS : $urandom);
    sel = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("rst_seq_idcmd", {m_read, m_addr}, 2'b10);
    waitrequest = 1'b0;
    readdatavalid = 1'b1;
    readdata = EXP_ID;
    tick();
    chk("rst_seq_tscmd", {m_read, m_addr}, 2'b11);
    readdatavalid = 1'b0;
    tick();
    chk("rst_seq_tswait", {m_read, m_addr, m_busy}, 3'b011);
    reset = 1'b1;
    tick();
    zero("mid_rst");
    reset = 1'b0;
    readdatavalid = 1'b1;
    readdata = EXP_TS;
    run(0, 255, 1, 2, EXP_ID, 2, 3, EXP_TS);
    for (int i = 0; i < 12; i++)
      run(1, 255, $urandom_range(3), $urandom_range(3), $urandom_range(1) ? EXP_ID : $urandom,
          $urandom_range(3), $urandom_range(3), $urandom_range(1) ? EXP_TS : $urandom);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
